// File: rtl/exhaustive_stim_capture.sv
// rtl/exhaustive_stim_capture.sv - exhaustive pattern sequencer with response capture and MISR signature
module exhaustive_stim_capture #(
    parameter int               N_IN   = 4,
    parameter int               SETTLE = 1,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = 16'h1021
) (
    input  logic                   CK,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   dut_out,
    output logic [N_IN-1:0]        N_out,
    output logic [N_IN-1:0]        pattern_idx,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   resp_vec,
    output logic [SIG_W-1:0]       signature
);

    localparam int P  = 1 << N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0]   SETTLE_V = CW'(SETTLE);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(P - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            fb;

    // The pattern register doubles as the index, so the driven pattern and
    // the capture slot can never disagree.
    assign pattern_idx = N_out;
    assign fb          = signature[SIG_W-1] ^ dut_out;

    always_ff @(posedge CK) begin
        if (!reset) begin
            state     <= S_IDLE;
            N_out     <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            resp_vec  <= '0;
            signature <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        resp_vec  <= '0;
                        signature <= '0;
                        N_out     <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        state     <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    cnt   <= SETTLE_V;
                    state <= (SETTLE > 0) ? S_WAIT : S_SAMPLE;
                end
                S_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_ONE)
                        state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    resp_vec[N_out] <= dut_out;
                    signature       <= {signature[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
                    // Last pattern ends the run instead of wrapping the index.
                    if (N_out == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        N_out <= N_out + 1'b1;
                        state <= S_APPLY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exhaustive_stim_capture.sv
// tb/tb_exhaustive_stim_capture.sv - randomized truth-table bench for exhaustive_stim_capture
module tb_exhaustive_stim_capture;

    logic        ck = 1'b0;
    logic [1:0]  rst_n;
    logic [1:0]  start_v;
    logic [1:0]  dout_v;
    logic [1:0]  busy_v;
    logic [1:0]  done_v;
    logic [3:0]  nout_v [2];
    logic [3:0]  pidx_v [2];
    logic [15:0] resp_v [2];
    logic [15:0] sig_v  [2];
    logic [15:0] tt     [2];

    int vectors    = 0;
    int miscompares = 0;

    always #5 ck = ~ck;

    // Instance 0 settles for one cycle, instance 1 samples immediately.
    always_comb begin
        dout_v    = '0;
        dout_v[0] = tt[0][nout_v[0]];
        dout_v[1] = tt[1][nout_v[1]];
    end

    exhaustive_stim_capture #(.N_IN(4), .SETTLE(1), .SIG_W(16), .POLY(16'h1021)) u_dut_s1 (
        .CK(ck), .reset(rst_n[0]), .start(start_v[0]), .dut_out(dout_v[0]),
        .N_out(nout_v[0]), .pattern_idx(pidx_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .resp_vec(resp_v[0]), .signature(sig_v[0])
    );

    exhaustive_stim_capture #(.N_IN(4), .SETTLE(0), .SIG_W(16), .POLY(16'h1021)) u_dut_s0 (
        .CK(ck), .reset(rst_n[1]), .start(start_v[1]), .dut_out(dout_v[1]),
        .N_out(nout_v[1]), .pattern_idx(pidx_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .resp_vec(resp_v[1]), .signature(sig_v[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Signature as the remainder-style shift of the response stream, pattern 0 first.
    function automatic logic [15:0] model_sig(input logic [15:0] r);
        logic [15:0] s = '0;
        for (int i = 0; i < 16; i++)
            s = {s[14:0], 1'b0} ^ ((s[15] ^ r[i]) ? 16'h1021 : 16'h0000);
        return s;
    endfunction

    function automatic logic [15:0] parity_table();
        logic [15:0] t;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v = 4'(i);
            t[i] = ^v;
        end
        return t;
    endfunction

    task automatic check_idle(input int k, input string tag);
        check($sformatf("%s_flags%0d", tag, k), {busy_v[k], done_v[k]}, 2'b00);
        check($sformatf("%s_nout%0d", tag, k), {nout_v[k], pidx_v[k]}, 8'h00);
        check($sformatf("%s_res%0d", tag, k), {resp_v[k], sig_v[k]}, 32'h0);
    endtask

    task automatic check_final(input int k, input string tag, input logic [15:0] truth);
        check($sformatf("%s_done%0d", tag, k), {busy_v[k], done_v[k]}, 2'b01);
        check($sformatf("%s_resp%0d", tag, k), resp_v[k], truth);
        check($sformatf("%s_sig%0d", tag, k), sig_v[k], model_sig(truth));
        check($sformatf("%s_nout%0d", tag, k), {nout_v[k], pidx_v[k]}, 8'hFF);
    endtask

    // One full run: start pulse, optional start glitch while busy, then hold-in-DONE check.
    task automatic run(input int k, input logic [15:0] truth, input int glitch_at, input string tag);
        int per = (k == 0) ? 3 : 2;
        int nb = 0;
        int seq_err = 0;
        tt[k] = truth;
        @(negedge ck) start_v[k] = 1'b1;
        @(negedge ck) start_v[k] = 1'b0;
        check($sformatf("%s_clear%0d", tag, k), {busy_v[k], resp_v[k], sig_v[k]}, {1'b1, 32'h0});
        while (busy_v[k] && nb < 400) begin
            if (int'(nout_v[k]) != nb / per || pidx_v[k] != nout_v[k]) seq_err++;
            start_v[k] = (glitch_at >= 0 && int'(nout_v[k]) == glitch_at && nb % per == 0);
            nb++;
            @(negedge ck);
        end
        start_v[k] = 1'b0;
        check($sformatf("%s_busy_cycles%0d", tag, k), nb, 16 * per);
        check($sformatf("%s_seq%0d", tag, k), seq_err, 0);
        check_final(k, tag, truth);
        repeat (3) @(negedge ck);
        check_final(k, {tag, "_hold"}, truth);
    endtask

    initial begin
        logic [15:0] par;
        int nb;
        par = parity_table();
        tt[0] = 16'hFFFF;
        tt[1] = 16'hFFFF;
        rst_n = 2'b00;
        start_v = 2'b11;
        repeat (3) @(negedge ck);
        check_idle(0, "rst");
        check_idle(1, "rst");
        rst_n = 2'b11;
        start_v = 2'b00;
        repeat (5) @(negedge ck);
        check_idle(0, "post_rst");
        check_idle(1, "post_rst");

        run(0, par, -1, "parity");
        check("parity_const", resp_v[0], 16'h6996);
        run(0, 16'h8000, -1, "last_only");
        check("last_only_const", sig_v[0], 16'h1021);
        run(1, 16'h0000, -1, "zero_s0");
        run(0, par, 5, "glitch");
        run(0, par, -1, "restart");

        for (int i = 0; i < 6; i++) begin
            int k = int'($urandom_range(1, 0));
            int g = int'($urandom_range(16, 0)) - 1;
            run(k, 16'($urandom), g, $sformatf("rnd%0d", i));
        end

        // Start held high through DONE reruns immediately.
        tt[1] = 16'($urandom);
        @(negedge ck) start_v[1] = 1'b1;
        @(negedge ck);
        nb = 0;
        while (!done_v[1] && nb < 200) begin
            @(negedge ck);
            nb++;
        end
        check("held_done", done_v[1], 1'b1);
        check("held_resp", resp_v[1], tt[1]);
        @(negedge ck);
        check("held_rerun", {busy_v[1], done_v[1], resp_v[1], sig_v[1]}, {2'b10, 32'h0});
        start_v[1] = 1'b0;
        nb = 0;
        while (!done_v[1] && nb < 200) begin
            @(negedge ck);
            nb++;
        end
        check_final(1, "held_final", tt[1]);

        // Reset in the middle of a run discards everything.
        tt[0] = par;
        @(negedge ck) start_v[0] = 1'b1;
        @(negedge ck) start_v[0] = 1'b0;
        nb = 0;
        while (pidx_v[0] != 4'd7 && nb < 200) begin
            @(negedge ck);
            nb++;
        end
        check("mid_reached7", pidx_v[0], 4'd7);
        rst_n[0] = 1'b0;
        @(negedge ck) rst_n[0] = 1'b1;
        check_idle(0, "mid_rst");
        repeat (2) @(negedge ck);
        check_idle(0, "mid_rst_idle");
        run(0, par, -1, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
